// File: rtl/serial_adder_pkg.sv
// ============================================================================
// Module      : serial_adder_pkg
// Description : Shared types and constants for the bit-serial adder controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Bit counter width; never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

`default_nettype wire

// File: rtl/fulladder1.sv
// ============================================================================
// Module      : fulladder1
// Description : Combinational 1-bit full-adder cell.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fulladder1 (
    output logic sum,
    output logic cout,
    input  logic a,
    input  logic b,
    input  logic cin
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

`default_nettype wire

// File: rtl/serial_adder_ctrl.sv
// ============================================================================
// Module      : serial_adder_ctrl
// Description : Bit-serial adder sequencing one full-adder cell LSB first.
//               Optional subtract mode when SERIAL_ADDER_SUB_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int               CNT_W      = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(WIDTH - 1);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_sum_sh;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    logic             w_cell_sum;
    logic             w_cell_cout;
    logic             w_last;
    logic [WIDTH-1:0] w_b_load;
    logic             w_c_load;
    logic [WIDTH-1:0] w_sum_next;

`ifdef SERIAL_ADDER_SUB_EN
    // a - b computed as a + ~b + 1; cin is ignored when subtracting.
    assign w_b_load = sub ? ~b : b;
    assign w_c_load = sub ? 1'b1 : cin;
`else
    assign w_b_load = b;
    assign w_c_load = cin;
`endif

    fulladder1 u_cell (
        .sum  (w_cell_sum),
        .cout (w_cell_cout),
        .a    (r_a_sh[0]),
        .b    (r_b_sh[0]),
        .cin  (r_carry)
    );

    assign w_last     = (r_cnt == c_last_cnt);
    assign w_sum_next = {w_cell_sum, r_sum_sh[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (w_last) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                busy   = 1'b1;
                done   = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Result registers are loaded on the final shift edge so that sum and
    // cout are already valid while done is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_sum_sh <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_sum    <= '0;
            r_cout   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a_sh  <= a;
                        r_b_sh  <= w_b_load;
                        r_carry <= w_c_load;
                        r_cnt   <= '0;
                    end
                end
                SHIFT: begin
                    r_a_sh   <= r_a_sh >> 1;
                    r_b_sh   <= r_b_sh >> 1;
                    r_sum_sh <= w_sum_next;
                    r_carry  <= w_cell_cout;
                    if (w_last) begin
                        r_sum  <= w_sum_next;
                        r_cout <= w_cell_cout;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;

endmodule

`default_nettype wire

// File: tb/tb_serial_adder_ctrl.sv
// ============================================================================
// Module      : tb_serial_adder_ctrl
// Description : Scoreboard bench for serial_adder_ctrl with WIDTH=8.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_adder_ctrl;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   busy_cnt = 0;
    exp_t sb_q[$];

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard whenever done is presented.
    always @(negedge clk) begin
        if (rst_n) begin
            if (busy) busy_cnt++;
            if (done) begin
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got done=1 want no result pending");
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("sum", 32'(sum), 32'(e.s));
                    check("cout", 32'(cout), 32'(e.c));
                    // Done cycle is the (W+1)th cycle, i.e. it begins W edges after accept.
                    check("done_latency", 32'(cyc - acc_cyc), 32'(W));
                    check("busy_cycles", 32'(busy_cnt), 32'(W + 1));
                end
            end
        end
    end

    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic,
                         input logic isub, input logic [W-1:0] es, input logic ec,
                         input bit expect_result);
        a     = ia;
        b     = ib;
        cin   = ic;
        sub   = isub;
        start = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        acc_cyc  = cyc;
        busy_cnt = 0;
        if (expect_result) sb_q.push_back('{s: es, c: ec});
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (sb_q.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL timeout: got pending=%0d busy=%0b want 0 and 0", sb_q.size(), busy);
            sb_q.delete();
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        check("reset_sum", 32'(sum), 0);
        check("reset_cout", 32'(cout), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        issue(8'h05, 8'h03, 1'b0, 1'b0, 8'h08, 1'b0, 1'b1);
        wait_idle();
        issue(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        wait_idle();
        issue(8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b1);
        wait_idle();
        issue(8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        wait_idle();

        // A start pulse during SHIFT must be ignored.
        issue(8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        a     = 8'hAA;
        b     = 8'h55;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle();
        repeat (12) @(posedge clk);
        #1;
        check("ignored_start_idle", 32'(busy), 0);

        // Reset mid-operation discards the result.
        issue(8'h7F, 8'h01, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 0);
        check("midrst_done", 32'(done), 0);
        check("midrst_sum", 32'(sum), 0);
        check("midrst_cout", 32'(cout), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_busy", 32'(busy), 0);
        issue(8'h02, 8'h02, 1'b0, 1'b0, 8'h04, 1'b0, 1'b1);
        wait_idle();

`ifdef SERIAL_ADDER_SUB_EN
        issue(8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1, 1'b1);
        wait_idle();
        issue(8'h00, 8'h01, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b1);
        wait_idle();
`endif

        repeat (12) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
